cpu_mem_stage: RTL

Memory stage of the 16-bit five-stage pipeline. Sits between the EX/MEM pipeline register (fed by the EX stage's ALU result, destination register and store data) and the WB stage. It drives a variable-latency data-memory request/ready handshake and stalls the upstream pipeline while an access is outstanding. It also owns the MEM/WB pipeline register and returns the EX→EX forwarding address.

---
 rtl/cpu_mem_stage.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_mem_stage.sv
// Memory stage of the 16-bit pipeline: data-memory handshake with bounded wait,
// upstream stall generation and the MEM/WB pipeline register.
module cpu_mem_stage #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_valid,
   input  logic [15:0] i_alu_result,
   input  logic [15:0] i_store_data,
   input  logic [3:0]  i_regW_in,
   input  logic        i_memRead,
   input  logic        i_memWrite,
   input  logic        i_regWrite,
   input  logic        i_memToReg,
   input  logic        i_ForwardM,
   input  logic [15:0] i_WB_fdata,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [15:0] o_dmem_addr,
   output logic [15:0] o_dmem_wdata,
   input  logic [15:0] i_dmem_rdata,
   input  logic        i_dmem_ready,
   output logic        o_stall,
   output logic [15:0] o_MEM_faddress,
   output logic        o_wb_valid,
   output logic        o_wb_regWrite,
   output logic [3:0]  o_wb_regW,
   output logic [15:0] o_wb_data,
   output logic        o_bus_err
);

   // state   | meaning
   // ST_IDLE | no access outstanding; live EX/MEM values drive the bus
   // ST_WAIT | access outstanding; latched values drive the bus, counting cycles
   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic        r_we;
   logic [3:0]  r_regW;
   logic        r_regWrite;
   logic        r_memToReg;

   logic        r_wb_valid;
   logic        r_wb_regWrite;
   logic [3:0]  r_wb_regW;
   logic [15:0] r_wb_data;
   logic        r_bus_err;

   logic        w_access;
   logic [15:0] w_live_wdata;
   logic        w_req;
   logic        w_we;
   logic [15:0] w_addr;
   logic [15:0] w_wdata;
   logic        w_stall;
   logic        w_latch;
   logic        w_complete;
   logic        w_timeout;
   logic [3:0]  w_wb_regW;
   logic        w_wb_regWrite;
   logic [15:0] w_wb_data;

   assign w_access     = i_mem_valid & (i_memRead | i_memWrite);
   assign w_live_wdata = i_ForwardM ? i_WB_fdata : i_store_data;

   always_comb begin
      w_state_nxt   = r_state;
      w_req         = 1'b0;
      w_we          = i_memWrite;
      w_addr        = i_alu_result;
      w_wdata       = w_live_wdata;
      w_stall       = 1'b0;
      w_latch       = 1'b0;
      w_complete    = 1'b0;
      w_timeout     = 1'b0;
      w_wb_regW     = i_regW_in;
      w_wb_regWrite = i_regWrite;
      w_wb_data     = i_memToReg ? i_dmem_rdata : i_alu_result;
      case (r_state)
         ST_IDLE: begin
            w_req = w_access;
            if (w_access && !i_dmem_ready) begin
               w_stall     = 1'b1;
               w_latch     = 1'b1;
               w_state_nxt = ST_WAIT;
            end else begin
               w_complete = i_mem_valid;
            end
         end
         ST_WAIT: begin
            w_req         = 1'b1;
            w_we          = r_we;
            w_addr        = r_addr;
            w_wdata       = r_wdata;
            w_wb_regW     = r_regW;
            w_wb_regWrite = r_regWrite;
            w_wb_data     = r_memToReg ? i_dmem_rdata : r_addr;
            // ready beats the timeout when both land in the same cycle
            if (i_dmem_ready) begin
               w_complete  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == TIMEOUT_CNT) begin
               w_complete  = 1'b1;
               w_timeout   = 1'b1;
               w_wb_data   = 16'h0000;
               w_state_nxt = ST_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 8'd0;
         r_addr     <= 16'h0000;
         r_wdata    <= 16'h0000;
         r_we       <= 1'b0;
         r_regW     <= 4'd0;
         r_regWrite <= 1'b0;
         r_memToReg <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) begin
            r_cnt      <= 8'd1;
            r_addr     <= i_alu_result;
            r_wdata    <= w_live_wdata;
            r_we       <= i_memWrite;
            r_regW     <= i_regW_in;
            r_regWrite <= i_regWrite;
            r_memToReg <= i_memToReg;
         end else if (r_state == ST_WAIT && !w_complete) begin
            r_cnt <= r_cnt + 8'd1;
         end else begin
            r_cnt <= 8'd0;
         end
      end
   end

   // MEM/WB register: data and destination hold across bubbles
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wb_valid    <= 1'b0;
         r_wb_regWrite <= 1'b0;
         r_wb_regW     <= 4'd0;
         r_wb_data     <= 16'h0000;
         r_bus_err     <= 1'b0;
      end else begin
         if (w_complete) begin
            r_wb_valid    <= 1'b1;
            r_wb_regWrite <= w_wb_regWrite;
            r_wb_regW     <= w_wb_regW;
            r_wb_data     <= w_wb_data;
         end else begin
            r_wb_valid    <= 1'b0;
            r_wb_regWrite <= 1'b0;
         end
         if (w_timeout)
            r_bus_err <= 1'b1;
      end
   end

   // reset gating makes req/stall fall the moment rst rises, even mid-access
   assign o_dmem_req     = w_req & ~i_rst;
   assign o_stall        = w_stall & ~i_rst;
   assign o_dmem_we      = w_we;
   assign o_dmem_addr    = w_addr;
   assign o_dmem_wdata   = w_wdata;
   assign o_MEM_faddress = i_alu_result;
   assign o_wb_valid     = r_wb_valid;
   assign o_wb_regWrite  = r_wb_regWrite;
   assign o_wb_regW      = r_wb_regW;
   assign o_wb_data      = r_wb_data;
   assign o_bus_err      = r_bus_err;

endmodule
